register_window_manager: RTL and testbench

//  SPARC V8 register-window controller for the DataPath, parametrised in NWINDOWS.

---
 rtl/register_window_manager.sv | 186 ++++++++++++++++++
 tb/tb_register_window_manager.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/register_window_manager.sv
// SPARC V8 register-window controller: owns CWP/WIM, maps logical r0..r31 onto the
// windowed physical register file and executes SAVE/RESTORE/TRAP_ENTRY via req/ack.
module register_window_manager #(
  parameter int                    NWINDOWS  = 8,
  parameter logic [NWINDOWS-1:0]   RESET_WIM = NWINDOWS'(8'h02),
  parameter int                    PHYS_W    = 8
) (
  input  logic                  Clk,
  input  logic                  RESET,
  input  logic                  win_req,
  input  logic [1:0]            win_op,
  output logic                  win_busy,
  output logic                  win_ack,
  output logic                  win_trap,
  output logic [7:0]            win_tt,
  input  logic                  wr_cwp_en,
  input  logic [4:0]            wr_cwp_data,
  input  logic                  wr_wim_en,
  input  logic [NWINDOWS-1:0]   wr_wim_data,
  output logic [4:0]            cwp,
  output logic [NWINDOWS-1:0]   wim,
  input  logic [4:0]            in_PA,
  input  logic [4:0]            in_PB,
  input  logic [4:0]            in_PC,
  output logic [PHYS_W-1:0]     phys_PA,
  output logic [PHYS_W-1:0]     phys_PB,
  output logic [PHYS_W-1:0]     phys_PC
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SAVE    = 2'b00;
  localparam logic [1:0] OP_RESTORE = 2'b01;
  localparam logic [1:0] OP_TRAP    = 2'b10;

  localparam logic [7:0] TT_NONE      = 8'h00;
  localparam logic [7:0] TT_OVERFLOW  = 8'h05;
  localparam logic [7:0] TT_UNDERFLOW = 8'h06;

  localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);
  localparam logic [5:0] NW6     = 6'(NWINDOWS);
  localparam logic [9:0] RING    = 10'(16 * NWINDOWS);

  state_t                state_r;
  logic [1:0]            op_r;
  logic [4:0]            cwp_r;
  logic [NWINDOWS-1:0]   wim_r;
  logic                  busy_r;
  logic                  ack_r;
  logic                  trap_r;
  logic [7:0]            tt_r;

  logic [4:0]            cwp_dec_s;
  logic [4:0]            cwp_inc_s;
  logic                  wim_dec_hit_s;
  logic                  wim_inc_hit_s;
  logic                  cwp_wr_ok_s;

  // Windowed operands wrap around a ring of 16*NWINDOWS registers; globals bypass it.
  function automatic logic [PHYS_W-1:0] map_reg(input logic [4:0] r, input logic [4:0] w);
    logic [9:0] off;
    if (r < 5'd8) begin
      off = {5'b00000, r};
    end else begin
      off = {1'b0, w, 4'b0000} + {5'b00000, r} - 10'd8;
      if (off >= RING) begin
        off = off - RING;
      end else begin
        off = off;
      end
      off = off + 10'd8;
    end
    return PHYS_W'(off);
  endfunction

  // Neighbour windows and their WIM bits, wrapping modulo NWINDOWS.
  always_comb begin
    cwp_dec_s     = 5'd0;
    cwp_inc_s     = 5'd0;
    wim_dec_hit_s = 1'b0;
    wim_inc_hit_s = 1'b0;
    if (cwp_r == 5'd0) begin
      cwp_dec_s = CWP_MAX;
    end else begin
      cwp_dec_s = cwp_r - 5'd1;
    end
    if (cwp_r == CWP_MAX) begin
      cwp_inc_s = 5'd0;
    end else begin
      cwp_inc_s = cwp_r + 5'd1;
    end
    wim_dec_hit_s = |(wim_r & ({{(NWINDOWS-1){1'b0}}, 1'b1} << cwp_dec_s));
    wim_inc_hit_s = |(wim_r & ({{(NWINDOWS-1){1'b0}}, 1'b1} << cwp_inc_s));
  end

  assign cwp_wr_ok_s = ({1'b0, wr_cwp_data} < NW6);

  // Window FSM: all architectural state and handshake outputs are registered here.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_r <= S_IDLE;
      op_r    <= 2'b11;
      cwp_r   <= 5'd0;
      wim_r   <= RESET_WIM;
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
      trap_r  <= 1'b0;
      tt_r    <= TT_NONE;
    end else begin
      case (state_r)
        S_IDLE: begin
          // Writes land on the same edge as an accepted request, so the op sees them.
          if (wr_cwp_en && cwp_wr_ok_s) begin
            cwp_r <= wr_cwp_data;
          end
          if (wr_wim_en) begin
            wim_r <= wr_wim_data;
          end
          if (win_req) begin
            op_r    <= win_op;
            busy_r  <= 1'b1;
            state_r <= S_CHECK;
          end
        end
        S_CHECK: begin
          ack_r   <= 1'b1;
          state_r <= S_DONE;
          case (op_r)
            OP_SAVE: begin
              if (wim_dec_hit_s) begin
                trap_r <= 1'b1;
                tt_r   <= TT_OVERFLOW;
              end else begin
                cwp_r <= cwp_dec_s;
              end
            end
            OP_RESTORE: begin
              if (wim_inc_hit_s) begin
                trap_r <= 1'b1;
                tt_r   <= TT_UNDERFLOW;
              end else begin
                cwp_r <= cwp_inc_s;
              end
            end
            OP_TRAP: begin
              cwp_r <= cwp_dec_s;
            end
            default: begin
              cwp_r <= cwp_r;
            end
          endcase
        end
        S_DONE: begin
          ack_r   <= 1'b0;
          trap_r  <= 1'b0;
          tt_r    <= TT_NONE;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          ack_r   <= 1'b0;
          trap_r  <= 1'b0;
          tt_r    <= TT_NONE;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign win_busy = busy_r;
  assign win_ack  = ack_r;
  assign win_trap = trap_r;
  assign win_tt   = tt_r;
  assign cwp      = cwp_r;
  assign wim      = wim_r;

  assign phys_PA = map_reg(in_PA, cwp_r);
  assign phys_PB = map_reg(in_PB, cwp_r);
  assign phys_PC = map_reg(in_PC, cwp_r);

endmodule

// File: tb/tb_register_window_manager.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle compared
// against a behavioural register-window model.
module tb_register_window_manager;
  localparam int N = 8;

  logic          Clk = 1'b0;
  logic          RESET;
  logic          win_req;
  logic [1:0]    win_op;
  logic          win_busy, win_ack, win_trap;
  logic [7:0]    win_tt;
  logic          wr_cwp_en;
  logic [4:0]    wr_cwp_data;
  logic          wr_wim_en;
  logic [N-1:0]  wr_wim_data;
  logic [4:0]    cwp;
  logic [N-1:0]  wim;
  logic [4:0]    in_PA, in_PB, in_PC;
  logic [7:0]    phys_PA, phys_PB, phys_PC;

  register_window_manager #(.NWINDOWS(N), .RESET_WIM(8'h02), .PHYS_W(8)) dut (
    .Clk(Clk), .RESET(RESET), .win_req(win_req), .win_op(win_op),
    .win_busy(win_busy), .win_ack(win_ack), .win_trap(win_trap), .win_tt(win_tt),
    .wr_cwp_en(wr_cwp_en), .wr_cwp_data(wr_cwp_data),
    .wr_wim_en(wr_wim_en), .wr_wim_data(wr_wim_data),
    .cwp(cwp), .wim(wim),
    .in_PA(in_PA), .in_PB(in_PB), .in_PC(in_PC),
    .phys_PA(phys_PA), .phys_PB(phys_PB), .phys_PC(phys_PC)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // model: age 0 = idle, 1 = request accepted, 2 = ack cycle
  int           m_cwp, m_age, m_op, m_trap, m_tt;
  logic [N-1:0] m_wim;

  function automatic int map_ref(int r, int w);
    if (r < 8) return r;
    return 8 + ((w * 16 + r - 8) % (16 * N));
  endfunction

  task automatic cmp(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int tgt;
    if (RESET) begin
      m_cwp = 0; m_wim = 8'h02; m_age = 0; m_trap = 0; m_tt = 0;
    end else if (m_age == 0) begin
      if (wr_cwp_en && int'(wr_cwp_data) < N) m_cwp = int'(wr_cwp_data);
      if (wr_wim_en) m_wim = wr_wim_data;
      if (win_req) begin m_op = int'(win_op); m_age = 1; end
    end else if (m_age == 1) begin
      tgt = (m_op == 1) ? (m_cwp + 1) % N : (m_cwp + N - 1) % N;
      m_trap = 0; m_tt = 0;
      if (m_op == 0 && m_wim[tgt]) begin m_trap = 1; m_tt = 5; end
      else if (m_op == 1 && m_wim[tgt]) begin m_trap = 1; m_tt = 6; end
      else if (m_op != 3) m_cwp = tgt;
      m_age = 2;
    end else begin
      m_age = 0; m_trap = 0; m_tt = 0;
    end
  endtask

  task automatic check_all();
    cmp("cwp", int'(cwp), m_cwp);
    cmp("wim", int'(wim), int'(m_wim));
    cmp("busy", int'(win_busy), (m_age != 0) ? 1 : 0);
    cmp("ack", int'(win_ack), (m_age == 2) ? 1 : 0);
    cmp("trap", int'(win_trap), m_trap);
    cmp("tt", int'(win_tt), m_tt);
    cmp("phys_PA", int'(phys_PA), map_ref(int'(in_PA), m_cwp));
    cmp("phys_PB", int'(phys_PB), map_ref(int'(in_PB), m_cwp));
    cmp("phys_PC", int'(phys_PC), map_ref(int'(in_PC), m_cwp));
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic quiet();
    RESET = 1'b0; win_req = 1'b0; win_op = 2'b11;
    wr_cwp_en = 1'b0; wr_cwp_data = 5'd0; wr_wim_en = 1'b0; wr_wim_data = '0;
  endtask

  task automatic run_op(input logic [1:0] op);
    win_req = 1'b1; win_op = op;
    step();
    win_req = 1'b0;
    step();
  endtask

  initial begin
    quiet();
    in_PA = 5'd0; in_PB = 5'd0; in_PC = 5'd0;
    RESET = 1'b1;
    step(); step();
    RESET = 1'b0;
    step();

    // reset state and global/windowed mapping at cwp 0
    cmp("t1_cwp", int'(cwp), 0);
    cmp("t1_wim", int'(wim), 2);
    cmp("t1_busy", int'(win_busy), 0);
    in_PA = 5'd8;  #1; cmp("t1_pa8", int'(phys_PA), 8);
    in_PA = 5'd24; #1; cmp("t1_pa24", int'(phys_PA), 24);
    in_PA = 5'd3;  #1; cmp("t1_pa3", int'(phys_PA), 3);

    // SAVE from cwp 0: ack on second edge, new ins alias old outs
    run_op(2'b00);
    cmp("t2_ack", int'(win_ack), 1);
    cmp("t2_trap", int'(win_trap), 0);
    cmp("t2_cwp", int'(cwp), 7);
    step();
    cmp("t2_ack_low", int'(win_ack), 0);
    in_PC = 5'd24; #1; cmp("t2_pc24", int'(phys_PC), 8);

    // RESTORE into invalid window 1
    wr_cwp_en = 1'b1; wr_cwp_data = 5'd0; step(); wr_cwp_en = 1'b0;
    run_op(2'b01);
    cmp("t3_trap", int'(win_trap), 1);
    cmp("t3_tt", int'(win_tt), 6);
    cmp("t3_cwp", int'(cwp), 0);
    step();

    // overflow then TRAP_ENTRY ignoring WIM
    wr_wim_en = 1'b1; wr_wim_data = 8'h80; step(); wr_wim_en = 1'b0;
    run_op(2'b00);
    cmp("t4_trap", int'(win_trap), 1);
    cmp("t4_tt", int'(win_tt), 5);
    cmp("t4_cwp", int'(cwp), 0);
    step();
    run_op(2'b10);
    cmp("t4_te_trap", int'(win_trap), 0);
    cmp("t4_te_cwp", int'(cwp), 7);
    step();

    // eight SAVEs wrap cwp 7..0; req held and CWP write during busy are ignored
    wr_wim_en = 1'b1; wr_wim_data = 8'h00; wr_cwp_en = 1'b1; wr_cwp_data = 5'd0;
    step(); quiet();
    for (int i = 1; i <= 8; i++) begin
      win_req = 1'b1; win_op = 2'b00;
      step();
      wr_cwp_en = 1'b1; wr_cwp_data = 5'd3;
      step();
      cmp("t5_cwp", int'(cwp), (8 - i) % 8);
      step();
      quiet();
    end
    wr_cwp_en = 1'b1; wr_cwp_data = 5'd9; step(); wr_cwp_en = 1'b0;
    cmp("t5_wr9", int'(cwp), 0);

    // reset while in CHECK aborts the op
    win_req = 1'b1; win_op = 2'b00; step();
    win_req = 1'b0; RESET = 1'b1; step();
    cmp("t6_ack", int'(win_ack), 0);
    cmp("t6_cwp", int'(cwp), 0);
    cmp("t6_wim", int'(wim), 2);
    cmp("t6_busy", int'(win_busy), 0);
    RESET = 1'b0; step();
    cmp("t6_no_ack", int'(win_ack), 0);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      RESET       = ($urandom_range(0, 99) == 0);
      win_req     = ($urandom_range(0, 2) == 0);
      win_op      = 2'($urandom_range(0, 3));
      wr_cwp_en   = ($urandom_range(0, 7) == 0);
      wr_cwp_data = 5'($urandom_range(0, 31));
      wr_wim_en   = ($urandom_range(0, 9) == 0);
      wr_wim_data = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      in_PA       = 5'($urandom_range(0, 31));
      in_PB       = 5'($urandom_range(0, 31));
      in_PC       = 5'($urandom_range(0, 31));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
